// File: rtl/sys_defs_pkg.sv
// Shared fixed-point constants and element type for the normalisation datapath.
package sys_defs;

  localparam int unsigned ARR_WIDTH = 4;
  localparam int unsigned FXP_N     = 16;
  // Fractional bits: only changes how raw values are read, never the arithmetic.
  localparam int unsigned FXP_R     = 8;

  typedef logic signed [FXP_N-1:0] fxp_t;

endpackage

// File: rtl/vec_sum.sv
// Combinational sign-extending sum of ARR_WIDTH signed elements, wide enough to never overflow.
module vec_sum
  import sys_defs::*;
#(
  parameter int unsigned ARR_WIDTH = sys_defs::ARR_WIDTH,
  parameter int unsigned FXP_N     = sys_defs::FXP_N,
  localparam int unsigned LOG_W    = $clog2(ARR_WIDTH),
  localparam int unsigned SUM_W    = FXP_N + LOG_W
) (
  input  logic signed [ARR_WIDTH-1:0][FXP_N-1:0] input_arr,
  output logic signed [SUM_W-1:0]                sum_c
);

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(ARR_WIDTH); i++) begin
      sum_c = sum_c + SUM_W'($signed({{LOG_W{input_arr[i][FXP_N-1]}}, input_arr[i]}));
    end
  end

endmodule

// File: rtl/vec_mean.sv
// Registered arithmetic mean of a signed fixed-point vector; one-cycle latency, full throughput.
module vec_mean
  import sys_defs::*;
#(
  parameter int unsigned ARR_WIDTH = sys_defs::ARR_WIDTH,
  parameter int unsigned FXP_N     = sys_defs::FXP_N,
  localparam int unsigned LOG_W    = $clog2(ARR_WIDTH),
  localparam int unsigned SUM_W    = FXP_N + LOG_W
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   in_valid,
  input  logic signed [ARR_WIDTH-1:0][FXP_N-1:0] input_arr,
  output logic                                   out_valid,
  output logic signed [FXP_N-1:0]                mean_out
);

  if ((ARR_WIDTH < 2) || ((ARR_WIDTH & (ARR_WIDTH - 1)) != 0)) begin : g_bad_width
    $error("vec_mean: ARR_WIDTH must be a power of two and at least 2");
  end

  logic signed [SUM_W-1:0] sum_c;
  logic signed [FXP_N-1:0] mean_d, mean_q;
  logic                    valid_d, valid_q;

  vec_sum #(
    .ARR_WIDTH (ARR_WIDTH),
    .FXP_N     (FXP_N)
  ) u_vec_sum (
    .input_arr (input_arr),
    .sum_c     (sum_c)
  );

  // Arithmetic shift floors toward -inf; the mean always fits back into FXP_N bits.
  always_comb begin
    valid_d = in_valid;
    mean_d  = mean_q;
    if (in_valid) begin
      mean_d = FXP_N'(sum_c >>> LOG_W);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mean_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      mean_q  <= mean_d;
      valid_q <= valid_d;
    end
  end

  assign mean_out  = mean_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_vec_mean.sv
// Scoreboard bench for vec_mean: directed vectors with hand-computed means.
module tb_vec_mean;

  localparam int unsigned AW = 4;
  localparam int unsigned N  = 16;

  logic                          clock;
  logic                          reset;
  logic                          in_valid;
  logic signed [AW-1:0][N-1:0]   input_arr;
  logic                          out_valid;
  logic signed [N-1:0]           mean_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] last_mean;

  vec_mean #(.ARR_WIDTH(AW), .FXP_N(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .input_arr (input_arr),
    .out_valid (out_valid),
    .mean_out  (mean_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: every presented result must match the oldest pending expectation.
  always @(negedge clock) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got %h want no result", mean_out);
      end else begin
        check("scoreboard_mean", mean_out, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [N-1:0] a0, input logic [N-1:0] a1,
                      input logic [N-1:0] a2, input logic [N-1:0] a3,
                      input logic [N-1:0] want);
    in_valid     = 1'b1;
    input_arr[0] = a0;
    input_arr[1] = a1;
    input_arr[2] = a2;
    input_arr[3] = a3;
    exp_q.push_back(want);
    last_mean = want;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    input_arr = '0;
    last_mean = '0;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    check("reset_mean", mean_out, 16'h0000);
    check("reset_valid", {15'b0, out_valid}, 16'h0000);
    reset = 1'b0;
    repeat (2) idle();
    @(negedge clock);
    check("idle_mean", mean_out, 16'h0000);
    check("idle_valid", {15'b0, out_valid}, 16'h0000);
    @(posedge clock);
    #1;

    send(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    send(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0280);
    send(16'h0280, 16'hFC80, 16'h0480, 16'hFA80, 16'hFF80);
    send(16'hF100, 16'hE980, 16'hDA80, 16'hD300, 16'hE200);
    send(16'h0A00, 16'h1400, 16'h1E00, 16'h2800, 16'h1900);
    send(16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    send(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
    send(16'h0003, 16'h0003, 16'h0003, 16'h0002, 16'h0002);
    send(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    send(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
    send(16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'hFFFF);

    // After the stream ends the last mean must hold with out_valid low.
    idle();
    @(negedge clock);
    check("hold_mean", mean_out, last_mean);
    check("hold_valid", {15'b0, out_valid}, 16'h0000);
    @(posedge clock);
    #1;

    send(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    idle();
    @(negedge clock);
    check("bubble_valid", {15'b0, out_valid}, 16'h0000);
    @(posedge clock);
    #1;
    send(16'h0A00, 16'h1400, 16'h1E00, 16'h2800, 16'h1900);

    // Reset wins over a simultaneous valid vector.
    reset        = 1'b1;
    in_valid     = 1'b1;
    input_arr[0] = 16'h0400;
    input_arr[1] = 16'h0400;
    input_arr[2] = 16'h0400;
    input_arr[3] = 16'h0400;
    @(posedge clock);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    check("rst_valid_mean", mean_out, 16'h0000);
    check("rst_valid_valid", {15'b0, out_valid}, 16'h0000);

    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_results: got %0d outstanding want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
